// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-sequencing controller for the 5-stage RISC-V core.
// Resolves load-use, taken-branch redirect and data-memory wait hazards, and forwards ALU operands.
module hazard_ctrl #(
   parameter int unsigned REDIRECT_CYCLES = 1,
   parameter int unsigned CNT_W           = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic             RegWriteE,
   input  logic             ResultSrcE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned RC_W   = 3;
   localparam logic [RC_W-1:0] RELOAD = RC_W'(REDIRECT_CYCLES - 1);
   localparam bit          MULTI  = (REDIRECT_CYCLES > 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [RC_W-1:0] rcnt, rcnt_nxt;
   logic            lu, mw;

   // Operand bypass: the younger Memory-stage result beats Writeback.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic       wr_m,
      input logic [4:0] rd_m,
      input logic       wr_w,
      input logic [4:0] rd_w
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
         sel = 2'b10;
      else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
         sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (rst_n) begin
         ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
         ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
      end
   end

   assign lu = ResultSrcE && RegWriteE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
   assign mw = MemReqM && !MemReadyM;

   // State and redirect counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         rcnt  <= '0;
      end else begin
         state <= state_nxt;
         rcnt  <= rcnt_nxt;
      end
   end

   // Next state and pipeline controls; a memory wait overrides everything else.
   always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      if (rst_n) begin
         unique case (state)
            RUN, MEM_WAIT: begin
               state_nxt = RUN;
               if (mw) begin
                  {StallF, StallD, StallE, StallM} = 4'b1111;
                  state_nxt = MEM_WAIT;
               end else if (PCSrcE) begin
                  FlushD = 1'b1;
                  FlushE = 1'b1;
                  if (MULTI) begin
                     state_nxt = REDIRECT;
                     rcnt_nxt  = RELOAD;
                  end
               end else if (lu) begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  FlushE = 1'b1;
               end
            end
            REDIRECT: begin
               if (mw) begin
                  {StallF, StallD, StallE, StallM} = 4'b1111;
               end else if (PCSrcE) begin
                  FlushD   = 1'b1;
                  FlushE   = 1'b1;
                  rcnt_nxt = RELOAD;
               end else begin
                  FlushD   = 1'b1;
                  rcnt_nxt = rcnt - RC_W'(1);
                  if (rcnt == RC_W'(1))
                     state_nxt = RUN;
               end
            end
            default: begin
               state_nxt = RUN;
               rcnt_nxt  = '0;
            end
         endcase
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (StallF && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (FlushE && (flush_cnt != {CNT_W{1'b1}}))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: an event-priority reference model predicts each cycle,
// a negedge monitor compares. A narrow-counter second instance exercises saturation.
module tb_hazard_ctrl;

   logic clk, rst_n;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic RegWriteE, ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;

   logic StallF, StallD, StallE, StallM, FlushD, FlushE;
   logic [1:0] ForwardAE, ForwardBE;
   logic [31:0] stall_cnt, flush_cnt;

   logic s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE;
   logic [1:0] s_ForwardAE, s_ForwardBE;
   logic [3:0] s_stall_cnt, s_flush_cnt;

   hazard_ctrl #(.REDIRECT_CYCLES(3), .CNT_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
      .MemReadyM(MemReadyM), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   hazard_ctrl #(.REDIRECT_CYCLES(1), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
      .MemReadyM(MemReadyM), .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE),
      .StallM(s_StallM), .FlushD(s_FlushD), .FlushE(s_FlushE), .ForwardAE(s_ForwardAE),
      .ForwardBE(s_ForwardBE), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  fa, fb;
      logic [5:0]  ctl, sctl;
      logic [31:0] sc, fc;
      logic [3:0]  ssc, sfc;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;

   // Reference state: remaining redirect flush cycles and counter values per instance.
   int              rl[2];
   longint unsigned sc[2], fc[2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   // ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE}
   task automatic model(input int i, input int rc, input longint unsigned maxv,
                        output logic [5:0] ctl, output longint unsigned sco, output longint unsigned fco);
      bit wait_m, lu_m;
      wait_m = MemReqM && !MemReadyM;
      lu_m   = ResultSrcE && RegWriteE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      sco = sc[i];
      fco = fc[i];
      if (wait_m)                    ctl = 6'b111100;
      else if (rl[i] > 0 && !PCSrcE) begin ctl = 6'b000010; rl[i]--; end
      else if (PCSrcE)               begin ctl = 6'b000011; rl[i] = rc - 1; end
      else if (lu_m)                 ctl = 6'b110001;
      else                           ctl = 6'b000000;
      if (ctl[5] && sc[i] < maxv) sc[i]++;
      if (ctl[0] && fc[i] < maxv) fc[i]++;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin rl[i] = 0; sc[i] = 0; fc[i] = 0; end
   endtask

   // Predict this cycle's response, queue it, advance to the next cycle.
   task automatic step();
      exp_t e;
      longint unsigned a, b;
      e.fa = fwd(Rs1E);
      e.fb = fwd(Rs2E);
      model(0, 3, 64'hFFFF_FFFF, e.ctl, a, b);
      e.sc = 32'(a); e.fc = 32'(b);
      model(1, 1, 64'd15, e.sctl, a, b);
      e.ssc = 4'(a); e.sfc = 4'(b);
      q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic idle();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      RegWriteE = 0; ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0;
      PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
   endtask

   // Monitor: pop one prediction per cycle and compare with the presented outputs.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("ForwardAE", 32'(ForwardAE), 32'(e.fa));
         chk("ForwardBE", 32'(ForwardBE), 32'(e.fb));
         chk("ctl", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE}), 32'(e.ctl));
         chk("stall_cnt", stall_cnt, e.sc);
         chk("flush_cnt", flush_cnt, e.fc);
         chk("sat_ctl", 32'({s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE}), 32'(e.sctl));
         chk("sat_stall_cnt", 32'(s_stall_cnt), 32'(e.ssc));
         chk("sat_flush_cnt", 32'(s_flush_cnt), 32'(e.sfc));
      end
   end

   initial begin
      idle();
      model_reset();
      rst_n = 1'b0;
      RdM = 5; RegWriteM = 1; Rs1E = 5;
      #3;
      chk("reset_ctl", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE}), 32'd0);
      chk("reset_fwd", 32'(ForwardAE), 32'd0);
      chk("reset_cnt", stall_cnt | flush_cnt, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Forwarding priority
      RdM = 5; RegWriteM = 1; Rs1E = 5;
      #3 chk("fwd_mem", 32'(ForwardAE), 32'd2);
      step();
      RdW = 5; RegWriteW = 1;
      #3 chk("fwd_mem_over_wb", 32'(ForwardAE), 32'd2);
      step();
      RdM = 0; Rs2E = 0;
      #3 chk("fwd_wb", 32'(ForwardAE), 32'd1);
      chk("fwd_b_x0", 32'(ForwardBE), 32'd0);
      step();

      // Load-use: one bubble cycle, then RdE=0 gives none
      idle();
      ResultSrcE = 1; RegWriteE = 1; RdE = 7; Rs2D = 7;
      #3 chk("lu_ctl", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE}), 32'h31);
      step();
      idle();
      #3 chk("lu_stall_cnt", stall_cnt, 32'd1);
      chk("lu_flush_cnt", flush_cnt, 32'd1);
      step();
      ResultSrcE = 1; RegWriteE = 1; RdE = 0; Rs2D = 0;
      step();

      // Memory wait for 3 cycles, then release
      idle();
      MemReqM = 1;
      repeat (3) step();
      MemReadyM = 1;
      #3 chk("mw_release", 32'({StallF, StallD, StallE, StallM}), 32'd0);
      step();
      idle();
      #3 chk("mw_stall_cnt", stall_cnt, 32'd4);
      step();

      // Redirect with simultaneous load-use: flush only
      PCSrcE = 1; ResultSrcE = 1; RegWriteE = 1; RdE = 3; Rs1D = 3;
      step();
      idle();
      repeat (3) step();

      // Branch during memory wait: stalls only, redirect resumes after release
      PCSrcE = 1; MemReqM = 1;
      #3 chk("br_mw_ctl", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE}), 32'h3C);
      step();
      MemReadyM = 1;
      step();
      idle();
      repeat (3) step();

      // Async reset in the middle of a memory wait
      MemReqM = 1; RdM = 9; RegWriteM = 1; Rs1E = 9;
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_ctl", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE}), 32'd0);
      chk("async_rst_fwd", 32'(ForwardAE), 32'd0);
      chk("async_rst_cnt", stall_cnt | flush_cnt | 32'(s_stall_cnt) | 32'(s_flush_cnt), 32'd0);
      model_reset();
      @(posedge clk); #1;
      idle();
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();

      // Saturation of the 4-bit counter instance
      MemReqM = 1;
      repeat (20) step();
      idle();
      #3 chk("sat_hold", 32'(s_stall_cnt), 32'hF);
      chk("wide_count", stall_cnt, 32'd20);
      step();

      // Randomised traffic
      for (int n = 0; n < 600; n++) begin
         Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
         RdW  = 5'($urandom_range(0, 3));
         RegWriteE  = 1'($urandom_range(0, 1));
         ResultSrcE = ($urandom_range(0, 9) < 4);
         RegWriteM  = 1'($urandom_range(0, 1));
         RegWriteW  = 1'($urandom_range(0, 1));
         PCSrcE     = ($urandom_range(0, 9) < 2);
         MemReqM    = ($urandom_range(0, 9) < 3);
         MemReadyM  = 1'($urandom_range(0, 1));
         step();
      end
      idle();
      step();

      for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
      if (q.size() > 0) chk("scoreboard_drain", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
